piso_arb_ctrl: RTL

PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

---
 rtl/piso_arb_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/piso_arb_ctrl.sv
// Two-requester round-robin parallel-in/serial-out framer, MSB first; first bit one cycle after accept.
// Backpressure: a requester waits with ready low until IDLE or the last bit of the current frame.
module piso_arb_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_src,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_last;
  logic             r_src;

  logic             w_window;
  logic             w_any;
  logic             w_gnt;
  logic             w_hs;
  logic [WIDTH-1:0] w_data;

  always_comb begin
    // Ready is gated by rst so nothing looks accepted while reset is held.
    w_window    = rst && ((r_state == IDLE) || (r_cnt == LAST_CNT));
    w_any       = req0_valid | req1_valid;
    w_gnt       = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    req0_ready  = w_window && w_any && !w_gnt;
    req1_ready  = w_window && w_any && w_gnt;
    w_hs        = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    w_data      = w_gnt ? req1_data : req0_data;
    w_state_nxt = r_state;
    if (w_hs) begin
      w_state_nxt = SHIFT;
    end else if ((r_state == SHIFT) && (r_cnt == LAST_CNT)) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_src   <= 1'b0;
    end else if (w_hs) begin
      r_shreg <= w_data;
      r_cnt   <= '0;
      r_last  <= w_gnt;
      r_src   <= w_gnt;
    end else if (r_state == SHIFT) begin
      r_shreg <= r_shreg << 1;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    sout_valid = (r_state == SHIFT);
    busy       = (r_state == SHIFT);
    sout       = (r_state == SHIFT) && r_shreg[WIDTH-1];
    sout_src   = r_src;
  end

endmodule
